// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the TLP virtual-channel FIFO bank: controller state
// encodings, destination field position and default FIFO thresholds.
package vc_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } arb_state_e;

  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned WORD_W   = 6;
  localparam int unsigned DEST_MSB = WORD_W - 1;
  localparam int unsigned DEST_LSB = WORD_W - 2;

  localparam int unsigned THR_HIGH_DEFAULT = 6;
  localparam int unsigned THR_LOW_DEFAULT  = 1;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [1:0] vc);
    return 4'b0001 << vc;
  endfunction

endpackage

// File: rtl/vc_arbiter_rr_picker4.sv
// Four-way round-robin picker: first requester after ptr_i (wrapping back to
// ptr_i itself last) wins; returns one-hot grant plus its index.
module rr_picker4
  import vc_arbiter_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic       vld_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx_o = ptr_i;
    cand  = '0;
    // Offset 4 wraps to 0, so the current pointer holder is scanned last.
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_i + 2'(k);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
        gnt_o = vc_onehot(cand);
      end
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Round-robin mover from the four input VC FIFOs to the four output FIFOs via
// one shared mux/demux; owns the FIFO thresholds and the full-error flags.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned DW           = WORD_W,
  parameter int unsigned THR_W        = 3,
  parameter int unsigned THR_HIGH_DEF = THR_HIGH_DEFAULT,
  parameter int unsigned THR_LOW_DEF  = THR_LOW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [THR_W-1:0] thr_high_in,
  input  logic [THR_W-1:0] thr_low_in,
  input  logic [3:0]       in_empty,
  input  logic [DW-1:0]    in_data0,
  input  logic [DW-1:0]    in_data1,
  input  logic [DW-1:0]    in_data2,
  input  logic [DW-1:0]    in_data3,
  input  logic [3:0]       out_pause,
  input  logic [3:0]       out_full,
  output logic [3:0]       pop,
  output logic [3:0]       push,
  output logic [DW-1:0]    data_out,
  output logic [THR_W-1:0] thr_high,
  output logic [THR_W-1:0] thr_low,
  output logic             idle,
  output logic [3:0]       error_full
);

  arb_state_e       state_q;
  logic [1:0]       ptr_q;
  logic [3:0]       push_q,  push_d;
  logic [DW-1:0]    data_q,  data_d;
  logic [THR_W-1:0] thr_high_q, thr_low_q;
  logic             idle_q;
  logic [3:0]       err_q;

  logic [DW-1:0]    in_word [NUM_VC];
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic             any_ready;

  assign in_word[0] = in_data0;
  assign in_word[1] = in_data1;
  assign in_word[2] = in_data2;
  assign in_word[3] = in_data3;

  assign any_ready = (in_empty != '1);

  // Inputs aimed at a paused output drop out of the request set, so they are
  // skipped rather than stalling the other channels.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      req[i] = (state_q == ST_ACTIVE) && !init && !in_empty[i] &&
               !out_pause[in_word[i][DW-1:DW-2]];
    end
  end

  rr_picker4 u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .vld_o (gnt_vld),
    .idx_o (gnt_idx)
  );

  always_comb begin
    push_d = '0;
    data_d = '0;
    if (gnt_vld) begin
      data_d = in_word[gnt_idx];
      push_d = vc_onehot(in_word[gnt_idx][DW-1:DW-2]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      ptr_q      <= 2'd3;
      push_q     <= '0;
      data_q     <= '0;
      thr_high_q <= THR_W'(THR_HIGH_DEF);
      thr_low_q  <= THR_W'(THR_LOW_DEF);
      idle_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      push_q <= push_d;
      data_q <= data_d;
      err_q  <= err_q | (push_q & out_full);
      if (gnt_vld) begin
        ptr_q <= gnt_idx;
      end
      // idle tracks the next state; push is always zero when entering IDLE.
      unique case (state_q)
        ST_RESET: begin
          state_q <= ST_INIT;
          idle_q  <= 1'b0;
        end
        ST_INIT: begin
          thr_high_q <= thr_high_in;
          thr_low_q  <= thr_low_in;
          err_q      <= '0;
          if (!init) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else begin
            idle_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
          end else if (any_ready) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
          end else begin
            idle_q  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
          end else if (!any_ready && !gnt_vld) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else begin
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RESET;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pop        = gnt;
  assign push       = push_q;
  assign data_out   = data_q;
  assign thr_high   = thr_high_q;
  assign thr_low    = thr_low_q;
  assign idle       = idle_q;
  assign error_full = err_q;

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Round-robin controller that moves TLP words from the four input virtual-channel FIFOs (VC0–VC3) into the four output FIFOs through a single shared mux/demux path. Picks one eligible input per cycle and pops it. Steers the word to the output FIFO named by its destination bits. Honours the output FIFOs' pause (almost-full) flags and owns their threshold configuration. Sits between the input FIFO bank and the output FIFO bank, beside the flow-control FSM.

## Interface
Parameters:
- DW, 6, word width; bits [DW-1:DW-2] are the destination VC.
- THR_W, 3, threshold width (FIFO depth 8).
- THR_HIGH_DEF, 6, almost-full threshold value after reset.
- THR_LOW_DEF, 1, almost-empty threshold value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- init  in  1  high = enter/stay in INIT and capture thresholds.
- thr_high_in  in  THR_W  almost-full threshold to capture in INIT.
- thr_low_in  in  THR_W  almost-empty threshold to capture in INIT.
- in_empty  in  4  input FIFO empty flags.
- in_data0..in_data3  in  DW each  input FIFO head words (first-word-fall-through, valid when empty=0).
- out_pause  in  4  output FIFO almost-full flags.
- out_full  in  4  output FIFO full flags.
- pop  out  4  one-hot pop to input FIFOs (combinational).
- push  out  4  one-hot push to output FIFOs (registered).
- data_out  out  DW  word to output FIFOs (registered).
- thr_high, thr_low  out  THR_W  thresholds driven to all FIFOs (registered).
- idle  out  1  registered; high in IDLE with nothing in flight.
- error_full  out  4  sticky; bit d set on a push to a full output d.

## Operation
- One-hot states: RESET, INIT, IDLE, ACTIVE.
- reset low (async): state=RESET, push=0, data_out=0, idle=0, error_full=0, thr_high=THR_HIGH_DEF, thr_low=THR_LOW_DEF, rr pointer=3 (so VC0 has first priority).
- RESET → INIT on the first edge after reset deasserts.
- INIT: thr_high/thr_low load from the *_in ports every cycle. error_full clears. pop=0. Leaves to IDLE on the first edge with init=0.
- IDLE: any in_empty bit low → ACTIVE. init=1 → INIT, with priority over ACTIVE.
- ACTIVE transitions:
  - init=1 → INIT after the current cycle. The in-flight push still completes. No new pop in the cycle init is seen.
  - in_empty=4'b1111 with no pop this cycle → IDLE.
- Eligibility: input i is eligible when state=ACTIVE, init=0, in_empty[i]=0 and out_pause[dest_i]=0, where dest_i=in_data_i[DW-1:DW-2].
- Grant: the first eligible index scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). pop[grant]=1. ptr ← grant. ptr is unchanged when nothing is granted.
- Same destination from several inputs resolves by the same round-robin rule; at most one pop and one push per cycle.
- error_full[d] sets when push[d]=1 and out_full[d]=1 in the same cycle.
- Paused destinations: inputs whose destination is paused are skipped, not blocked; other VCs continue.

## Timing
- pop is combinational in cycle t.
- Next edge: data_out ← head word of the granted input, push[dest] ← 1. Latency is one cycle, throughput one word per cycle.
- push and data_out drop to 0 the cycle after a cycle with no grant.
- Pause sampling: out_pause is sampled in the grant cycle. The output FIFO must assert pause with at least one free slot, so thr_high ≤ depth−1.
- idle=1 exactly in cycles where state=IDLE and push=0.

## Structure
- Shared package/include for the TLP FIFO bank: state encodings, DEST_MSB/DEST_LSB, and default thresholds, shared with the flow-control FSM.
- One natural sub-module: rr_picker4 (4-bit request, 2-bit pointer → one-hot grant).
- The datapath mux/demux is inside vc_arbiter.

## Test plan
- Reset/config: hold reset low with thr_high_in=5 → outputs at reset values and thr_high=6. Then release reset with init=1 for 3 cycles, thr_high_in=5, thr_low_in=2 → thr_high=5, thr_low=2, state reaches IDLE, idle=1.
- Fairness: all four inputs non-empty, all dest=0, no pause → pop sequence 0001,0010,0100,1000,0001…; push=0001 each cycle one cycle later.
- Steering: in_data2=6'b11_0101 alone non-empty → pop=0100, next cycle push=1000, data_out=6'b110101.
- Pause skip: VC0 dest=1 with out_pause[1]=1, VC1 dest=2 → only VC1 popped. Release the pause → VC0 popped on the next round-robin turn.
- Error: force out_full[3]=1, out_pause[3]=0 while a dest-3 word is pushed → error_full=1000 stays until the next INIT.
- init mid-stream: init=1 during continuous traffic → the in-flight push completes, pop=0 from that cycle, state=INIT. After init=0, state=IDLE, then ACTIVE, and arbitration resumes from the saved ptr.
